// File: rtl/cmp_event_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : cmp_event_debouncer_if
// Brief    : Comparator flag samples in, debounced relation and event pulses out.
// Revision : 1.0
// ============================================================================
interface cmp_event_debouncer_if;
  logic       sample_valid;
  logic       A_gt_B;
  logic       A_lt_B;
  logic       A_eq_B;
  logic [1:0] rel_state;
  logic       rel_known;
  logic       change_pulse;
  logic       flag_err;

  modport master (
    output sample_valid, A_gt_B, A_lt_B, A_eq_B,
    input  rel_state, rel_known, change_pulse, flag_err
  );

  modport slave (
    input  sample_valid, A_gt_B, A_lt_B, A_eq_B,
    output rel_state, rel_known, change_pulse, flag_err
  );
endinterface
`default_nettype wire

// File: rtl/cmp_event_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : cmp_event_debouncer
// Brief    : Debounces comparator flags into a registered relation state.
//            Sample counters are built only with `define CMP_EVT_STATS_EN.
// Revision : 1.0
// ============================================================================
module cmp_event_debouncer #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  cmp_event_debouncer_if.slave     bus
`ifdef CMP_EVT_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         gt_cnt,
  output logic [CNT_W-1:0]         lt_cnt,
  output logic [CNT_W-1:0]         eq_cnt,
  output logic [CNT_W-1:0]         err_cnt
`endif
);

  localparam logic [1:0] c_REL_UNKNOWN = 2'b00;
  localparam logic [1:0] c_REL_LT      = 2'b01;
  localparam logic [1:0] c_REL_EQ      = 2'b10;
  localparam logic [1:0] c_REL_GT      = 2'b11;
  localparam logic [4:0] c_DEBOUNCE    = 5'(DEBOUNCE);

  if (DEBOUNCE < 1 || DEBOUNCE > 15 || CNT_W < 1) begin : g_cfg_err
    $error("cmp_event_debouncer: DEBOUNCE must be 1..15 and CNT_W at least 1");
  end

  logic       w_onehot;
  logic [1:0] w_dec;

  logic [1:0] r_rel;
  logic       r_known;
  logic       r_change;
  logic       r_err;
  logic [1:0] r_cand;
  logic [3:0] r_run;

  assign w_onehot = $onehot({bus.A_gt_B, bus.A_lt_B, bus.A_eq_B});

  always_comb begin
    w_dec = c_REL_UNKNOWN;
    if (bus.A_lt_B)      w_dec = c_REL_LT;
    else if (bus.A_eq_B) w_dec = c_REL_EQ;
    else if (bus.A_gt_B) w_dec = c_REL_GT;
  end

  // Idle cycles fall through untouched, so gaps between samples never break a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rel    <= c_REL_UNKNOWN;
      r_known  <= 1'b0;
      r_change <= 1'b0;
      r_err    <= 1'b0;
      r_cand   <= c_REL_UNKNOWN;
      r_run    <= 4'd0;
    end else begin
      r_change <= 1'b0;
      r_err    <= 1'b0;
      if (bus.sample_valid) begin
        if (!w_onehot) begin
          r_err <= 1'b1;
          r_run <= 4'd0;
        end else if (w_dec == r_rel) begin
          r_run <= 4'd0;
        end else if (w_dec == r_cand && r_run != 4'd0) begin
          if (({1'b0, r_run} + 5'd1) == c_DEBOUNCE) begin
            r_rel    <= w_dec;
            r_known  <= 1'b1;
            r_change <= 1'b1;
            r_run    <= 4'd0;
          end else begin
            r_run <= r_run + 4'd1;
          end
        end else begin
          r_cand <= w_dec;
          if (DEBOUNCE == 1) begin
            r_rel    <= w_dec;
            r_known  <= 1'b1;
            r_change <= 1'b1;
            r_run    <= 4'd0;
          end else begin
            r_run <= 4'd1;
          end
        end
      end
    end
  end

  assign bus.rel_state    = r_rel;
  assign bus.rel_known    = r_known;
  assign bus.change_pulse = r_change;
  assign bus.flag_err     = r_err;

`ifdef CMP_EVT_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Clear wins over a same-cycle increment; all counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gt_cnt  <= '0;
      r_lt_cnt  <= '0;
      r_eq_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (stats_clr) begin
      r_gt_cnt  <= '0;
      r_lt_cnt  <= '0;
      r_eq_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (bus.sample_valid) begin
      if (!w_onehot) begin
        if (r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + c_CNT_ONE;
      end else begin
        case (w_dec)
          c_REL_GT: if (r_gt_cnt != c_CNT_MAX) r_gt_cnt <= r_gt_cnt + c_CNT_ONE;
          c_REL_LT: if (r_lt_cnt != c_CNT_MAX) r_lt_cnt <= r_lt_cnt + c_CNT_ONE;
          c_REL_EQ: if (r_eq_cnt != c_CNT_MAX) r_eq_cnt <= r_eq_cnt + c_CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  assign gt_cnt  = r_gt_cnt;
  assign lt_cnt  = r_lt_cnt;
  assign eq_cnt  = r_eq_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_event_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_event_debouncer
// Brief    : Randomized scoreboard bench for cmp_event_debouncer.
// Revision : 1.0
// ============================================================================
module tb_cmp_event_debouncer;

  localparam int DEB      = 3;
  localparam int TB_CNT_W = 2;

  typedef struct {
    bit         is_err;
    logic [1:0] rel;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  ev_t        evq[$];
  logic [1:0] streak[$];
  logic [1:0] m_rel = 2'b00;

  cmp_event_debouncer_if bus ();

`ifdef CMP_EVT_STATS_EN
  logic                stats_clr = 1'b0;
  logic [TB_CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt, err_cnt;
  int                  m_gt = 0, m_lt = 0, m_eq = 0, m_errc = 0;
  localparam int       CMAX = (1 << TB_CNT_W) - 1;
`endif

  cmp_event_debouncer #(
    .DEBOUNCE (DEB)
`ifdef CMP_EVT_STATS_EN
    , .CNT_W  (TB_CNT_W)
`endif
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef CMP_EVT_STATS_EN
    , .stats_clr (stats_clr),
    .gt_cnt    (gt_cnt),
    .lt_cnt    (lt_cnt),
    .eq_cnt    (eq_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flags are packed {gt, lt, eq}; relation codes are 1=LT, 2=EQ, 3=GT.
  function automatic logic [2:0] rel2flags(input logic [1:0] r);
    case (r)
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Reference: the relation moves once DEB legal samples in a row agree on a
  // new value; a sample matching the current relation or an illegal one
  // breaks the streak, idle cycles are invisible.
  task automatic model_step(input logic v, input logic [2:0] f, input logic clr);
    logic [1:0] d;
    bit         legal;
    legal = (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    d     = (f == 3'b010) ? 2'b01 : (f == 3'b001) ? 2'b10 : 2'b11;
`ifdef CMP_EVT_STATS_EN
    if (clr) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_errc = 0;
    end else if (v) begin
      if (!legal)          m_errc = (m_errc < CMAX) ? m_errc + 1 : CMAX;
      else if (d == 2'b11) m_gt   = (m_gt   < CMAX) ? m_gt   + 1 : CMAX;
      else if (d == 2'b01) m_lt   = (m_lt   < CMAX) ? m_lt   + 1 : CMAX;
      else                 m_eq   = (m_eq   < CMAX) ? m_eq   + 1 : CMAX;
    end
`else
    if (clr) begin end
`endif
    if (!v) return;
    if (!legal) begin
      streak.delete();
      evq.push_back('{is_err: 1'b1, rel: m_rel, cyc: cyc + 1});
    end else if (d == m_rel) begin
      streak.delete();
    end else begin
      if (streak.size() == 0 || streak[0] != d) streak.delete();
      streak.push_back(d);
      if (streak.size() == DEB) begin
        m_rel = d;
        streak.delete();
        evq.push_back('{is_err: 1'b0, rel: d, cyc: cyc + 1});
      end
    end
  endtask

  task automatic apply(input logic v, input logic [2:0] f, input logic clr = 1'b0);
    @(negedge clk);
    bus.sample_valid = v;
    {bus.A_gt_B, bus.A_lt_B, bus.A_eq_B} = f;
`ifdef CMP_EVT_STATS_EN
    stats_clr = clr;
`endif
    model_step(v, f, clr);
  endtask

  task automatic rel_samples(input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) apply(1'b1, rel2flags(r));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 3'b000);
  endtask

  task automatic check_state(input string name);
    idle(1);
    @(negedge clk);
    n_vec++;
    if (bus.rel_state !== m_rel || bus.rel_known !== (m_rel != 2'b00)) begin
      n_err++;
      $display("FAIL %s: rel_state=%b rel_known=%b, expected rel_state=%b rel_known=%b",
               name, bus.rel_state, bus.rel_known, m_rel, (m_rel != 2'b00));
    end
`ifdef CMP_EVT_STATS_EN
    n_vec++;
    if (gt_cnt !== TB_CNT_W'(m_gt) || lt_cnt !== TB_CNT_W'(m_lt) ||
        eq_cnt !== TB_CNT_W'(m_eq) || err_cnt !== TB_CNT_W'(m_errc)) begin
      n_err++;
      $display("FAIL %s counters: gt/lt/eq/err=%0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d",
               name, gt_cnt, lt_cnt, eq_cnt, err_cnt, m_gt, m_lt, m_eq, m_errc);
    end
`endif
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if (bus.rel_state !== 2'b00 || bus.rel_known !== 1'b0 ||
        bus.change_pulse !== 1'b0 || bus.flag_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s: rel_state=%b known=%b change=%b err=%b, expected all zero",
               name, bus.rel_state, bus.rel_known, bus.change_pulse, bus.flag_err);
    end
`ifdef CMP_EVT_STATS_EN
    n_vec++;
    if (gt_cnt !== '0 || lt_cnt !== '0 || eq_cnt !== '0 || err_cnt !== '0) begin
      n_err++;
      $display("FAIL %s counters: gt/lt/eq/err=%0d/%0d/%0d/%0d, expected 0/0/0/0",
               name, gt_cnt, lt_cnt, eq_cnt, err_cnt);
    end
`endif
  endtask

  task automatic model_reset();
    evq.delete();
    streak.delete();
    m_rel = 2'b00;
`ifdef CMP_EVT_STATS_EN
    m_gt = 0; m_lt = 0; m_eq = 0; m_errc = 0;
`endif
  endtask

  // Monitor: every pulse must match the next queued event, in the right cycle.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse: no %s pulse seen, expected in cycle %0d (rel %b)",
                 e.is_err ? "flag_err" : "change_pulse", e.cyc, e.rel);
      end
      if (bus.change_pulse === 1'b1 && bus.flag_err === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL pulse_overlap: change_pulse and flag_err both high in cycle %0d", cyc);
        if (evq.size() > 0 && evq[0].cyc == cyc) void'(evq.pop_front());
      end else if (bus.change_pulse === 1'b1 || bus.flag_err === 1'b1) begin
        n_vec++;
        if (evq.size() == 0 || evq[0].cyc != cyc) begin
          n_err++;
          $display("FAIL unexpected_pulse: change=%b err=%b in cycle %0d, expected no pulse",
                   bus.change_pulse, bus.flag_err, cyc);
        end else begin
          e = evq.pop_front();
          if (e.is_err != bus.flag_err || bus.rel_state !== e.rel ||
              bus.rel_known !== (e.rel != 2'b00)) begin
            n_err++;
            $display("FAIL event_cycle_%0d: err=%b rel=%b known=%b, expected err=%b rel=%b known=%b",
                     cyc, bus.flag_err, bus.rel_state, bus.rel_known,
                     e.is_err, e.rel, (e.rel != 2'b00));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] pref;
    logic [2:0] bad;
    logic [2:0] bad_tab [5];
    bad_tab[0] = 3'b000; bad_tab[1] = 3'b011; bad_tab[2] = 3'b101;
    bad_tab[3] = 3'b110; bad_tab[4] = 3'b111;

    bus.sample_valid = 1'b0;
    {bus.A_gt_B, bus.A_lt_B, bus.A_eq_B} = 3'b000;
    #1;
    check_reset_outputs("reset_values");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    idle(10);
    check_state("idle_after_reset");

    rel_samples(2'b11, DEB);
    check_state("gt_after_three");

    apply(1'b1, rel2flags(2'b01)); apply(1'b1, rel2flags(2'b01));
    apply(1'b1, rel2flags(2'b11));
    rel_samples(2'b01, 3);
    check_state("lt_after_broken_run");

    rel_samples(2'b10, 3);
    check_state("eq_reached");
    apply(1'b1, rel2flags(2'b10)); idle(5); apply(1'b1, rel2flags(2'b10));
    apply(1'b1, rel2flags(2'b11)); idle(1);
    apply(1'b1, rel2flags(2'b11)); idle(2);
    apply(1'b1, rel2flags(2'b11));
    check_state("gt_across_idle_gaps");

    rel_samples(2'b01, 2);
    apply(1'b1, 3'b110);
    rel_samples(2'b01, 1);
    check_state("illegal_clears_run");
    rel_samples(2'b01, 2);
    check_state("lt_after_illegal");

`ifdef CMP_EVT_STATS_EN
    apply(1'b0, 3'b000, 1'b1);
    rel_samples(2'b10, 5);
    check_state("eq_cnt_saturates");
    apply(1'b1, rel2flags(2'b10), 1'b1);
    check_state("clear_beats_increment");
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) pref = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) begin
        bad = bad_tab[$urandom_range(0, 4)];
        apply(1'b1, bad);
      end else begin
        apply(($urandom_range(0, 9) < 7), rel2flags(pref),
              ($urandom_range(0, 49) == 0));
      end
      if (i % 100 == 99) check_state("random_phase");
    end

    rel_samples(2'b10, 2);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_mid_run");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rel_samples(2'b01, DEB - 1);
    check_state("no_change_short_run_after_reset");
    rel_samples(2'b01, DEB);
    check_state("lt_after_reset");

    idle(4);
    n_vec++;
    if (evq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected events never seen, expected 0", evq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
